systolic_tile_ctrl: RTL and testbench

Sequences one output tile of the mac_cell systolic array, ROWS x COLS cells, through four phases: clear, skewed operand feed, completion wait and row drain.
- Latches per-tile config (FP8 format, BF16 output enable, reduction depth K) and holds it stable on the array for the whole tile.
- Fetches operands from the edge operand buffers.
- Times out if the array never reports completion.
- Sits between the top-level command interface and the array/operand buffers.

---
 rtl/systolic_tile_ctrl_if.sv | 36 +++
 rtl/systolic_tile_ctrl.sv | 138 +++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_tile_ctrl_if.sv
// Command, operand-buffer, array and drain signals of one systolic tile controller.
// Latency: n/a (wiring only).  Backpressure: drain_ready stalls the row drain.
interface systolic_tile_ctrl_if #(
    parameter int ROWS = 4,
    parameter int K_W  = 8
);
    logic                    start;
    logic [K_W-1:0]          k_len;
    logic                    mode_fp8_in;
    logic                    out_bf16_en_in;
    logic                    busy;
    logic                    done;
    logic                    err_timeout;
    logic                    mode_fp8;
    logic                    out_bf16_en;
    logic                    clear_accum;
    logic                    op_rd_en;
    logic [K_W-1:0]          op_rd_k;
    logic [ROWS-1:0]         valid_in;
    logic                    mac_valid_all;
    logic                    drain_valid;
    logic [$clog2(ROWS)-1:0] drain_row;
    logic                    drain_ready;

    modport master (
        input  start, k_len, mode_fp8_in, out_bf16_en_in, mac_valid_all, drain_ready,
        output busy, done, err_timeout, mode_fp8, out_bf16_en, clear_accum,
               op_rd_en, op_rd_k, valid_in, drain_valid, drain_row
    );

    modport slave (
        output start, k_len, mode_fp8_in, out_bf16_en_in, mac_valid_all, drain_ready,
        input  busy, done, err_timeout, mode_fp8, out_bf16_en, clear_accum,
               op_rd_en, op_rd_k, valid_in, drain_valid, drain_row
    );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// Sequences one systolic output tile: clear, skewed operand feed, completion wait, row drain.
// Latency: clear at +1, reads +2..k+1, valid_in[r] +3+r..k+2+r after start; done after drain.
// Backpressure: drain_ready holds the current drain_row indefinitely; WAIT is bounded by TIMEOUT.
module systolic_tile_ctrl #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_W     = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_tile_ctrl_if.master io
);
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(TIMEOUT);

    if (ROWS < 2 || COLS < 1 || TIMEOUT < 2) begin : g_bad_geometry
        $error("systolic_tile_ctrl: unsupported ROWS/COLS/TIMEOUT");
    end

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [K_W-1:0]  k_len_q;
    logic [K_W-1:0]  rd_k_q, rd_k_d;
    logic [TW-1:0]   wait_q, wait_d;
    logic [RW-1:0]   row_q, row_d;
    logic [ROWS-1:0] skew_q;
    logic            mode_q, bf16_q;
    logic            err_q, err_d;
    logic            zero_done_q;
    logic            accept;

    assign accept = (state_q == IDLE) && io.start;

    always_comb begin
        state_d = state_q;
        rd_k_d  = rd_k_q;
        wait_d  = wait_q;
        row_d   = row_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (io.k_len != '0) state_d = CLEAR;
                end
            end
            CLEAR: begin
                rd_k_d  = '0;
                state_d = FEED;
            end
            FEED: begin
                // compare against k_len-1 so the index never has to reach k_len (no wrap at 2^K_W-1)
                if (rd_k_q == k_len_q - K_W'(1)) begin
                    rd_k_d  = '0;
                    wait_d  = '0;
                    state_d = WAIT;
                end else begin
                    rd_k_d = rd_k_q + 1'b1;
                end
            end
            WAIT: begin
                if (io.mac_valid_all) begin
                    wait_d  = '0;
                    row_d   = '0;
                    state_d = DRAIN;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    wait_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DRAIN: begin
                if (io.drain_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            rd_k_q      <= '0;
            wait_q      <= '0;
            row_q       <= '0;
            skew_q      <= '0;
            mode_q      <= 1'b0;
            bf16_q      <= 1'b0;
            err_q       <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_k_q      <= rd_k_d;
            wait_q      <= wait_d;
            row_q       <= row_d;
            err_q       <= err_d;
            // lane 0 trails the read strobe by the one-cycle buffer latency
            skew_q      <= {skew_q[ROWS-2:0], state_q == FEED};
            zero_done_q <= accept && (io.k_len == '0);
            if (accept) begin
                k_len_q <= io.k_len;
                mode_q  <= io.mode_fp8_in;
                bf16_q  <= io.out_bf16_en_in;
            end
        end
    end

    assign io.busy        = (state_q != IDLE);
    assign io.done        = (state_q == DONE) || zero_done_q;
    assign io.err_timeout = err_q;
    assign io.mode_fp8    = mode_q;
    assign io.out_bf16_en = bf16_q;
    assign io.clear_accum = (state_q == CLEAR);
    assign io.op_rd_en    = (state_q == FEED);
    assign io.op_rd_k     = rd_k_q;
    assign io.valid_in    = skew_q;
    assign io.drain_valid = (state_q == DRAIN);
    assign io.drain_row   = row_q;
endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl: tiles are planned up front into per-cycle stimulus and expectation tables.
module tb_systolic_tile_ctrl;
    localparam int ROWS    = 4;
    localparam int K_W     = 8;
    localparam int TIMEOUT = 32;
    localparam int N       = 4000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_tile_ctrl_if #(.ROWS(ROWS), .K_W(K_W)) bus ();

    systolic_tile_ctrl #(.ROWS(ROWS), .COLS(4), .K_W(K_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    bit             in_start [N];
    logic [K_W-1:0] in_k     [N];
    bit             in_mode  [N];
    bit             in_bf16  [N];
    bit             in_mac   [N];
    bit             in_ready [N];
    bit             in_rst_n [N];

    bit              exp_busy  [N];
    bit              exp_done  [N];
    bit              exp_err   [N];
    bit              exp_mode  [N];
    bit              exp_bf16  [N];
    bit              exp_clear [N];
    bit              exp_rd    [N];
    int              exp_rdk   [N];
    logic [ROWS-1:0] exp_vin   [N];
    bit              exp_dv    [N];
    int              exp_row   [N];

    int cyc = 0;
    int last_cyc = 0;
    int total = 0;
    int bad = 0;
    int t4 = 0;

    // Lay one tile into the tables starting with the start request at cycle t.
    // d: cycles into WAIT before mac_valid_all rises (>= TIMEOUT means never).
    // rst_at: offset of a one-cycle reset inside the tile (0 = none).
    // ready_mode: 0 random, 1 always ready, 2 pattern 1,0,0 repeating.
    task automatic plan_tile(input int t, input int k, input bit m, input bit b, input int d,
                             input int rst_at, input int ready_mode, input bit junk,
                             output int t_next);
        int tw, tdone, c, row, j, rc;
        in_start[t] = 1'b1;
        in_k[t]     = K_W'(k);
        in_mode[t]  = m;
        in_bf16[t]  = b;
        for (int i = t + 1; i < N; i++) begin
            exp_mode[i] = m;
            exp_bf16[i] = b;
            exp_err[i]  = 1'b0;
        end
        if (k == 0) begin
            exp_done[t+1] = 1'b1;
            t_next = t + 1;
            return;
        end
        exp_clear[t+1] = 1'b1;
        for (int i = 0; i < k; i++) begin
            exp_rd[t+2+i]  = 1'b1;
            exp_rdk[t+2+i] = i;
        end
        for (int r = 0; r < ROWS; r++)
            for (int i = t + 3 + r; i <= t + k + 2 + r; i++) exp_vin[i][r] = 1'b1;
        tw = t + k + 2;
        if (d < TIMEOUT) begin
            for (int i = tw; i < tw + d; i++) in_mac[i] = 1'b0;
            in_mac[tw+d] = 1'b1;
            c = tw + d + 1;
            row = 0;
            j = 0;
            while (row < ROWS && c < N - 2) begin
                if (ready_mode == 1) in_ready[c] = 1'b1;
                if (ready_mode == 2) in_ready[c] = (j % 3 == 0);
                exp_dv[c]  = 1'b1;
                exp_row[c] = row;
                if (in_ready[c]) row++;
                c++;
                j++;
            end
            tdone = c;
        end else begin
            for (int i = tw; i < tw + TIMEOUT; i++) in_mac[i] = 1'b0;
            tdone = tw + TIMEOUT;
            for (int i = tdone; i < N; i++) exp_err[i] = 1'b1;
        end
        exp_done[tdone] = 1'b1;
        for (int i = t + 1; i <= tdone; i++) begin
            exp_busy[i] = 1'b1;
            if (junk && $urandom_range(0, 3) == 0) begin
                in_start[i] = 1'b1;
                in_k[i]     = K_W'($urandom_range(0, 255));
                in_mode[i]  = 1'($urandom_range(0, 1));
                in_bf16[i]  = 1'($urandom_range(0, 1));
            end
        end
        t_next = tdone + 1;
        if (rst_at > 0) begin
            rc = t + rst_at;
            in_rst_n[rc] = 1'b0;
            for (int i = rc + 1; i < N; i++) begin
                exp_mode[i] = 1'b0;
                exp_bf16[i] = 1'b0;
                exp_err[i]  = 1'b0;
            end
            for (int i = rc + 1; i <= tdone; i++) begin
                in_start[i] = 1'b0;
                exp_busy[i] = 1'b0; exp_done[i] = 1'b0; exp_clear[i] = 1'b0;
                exp_rd[i] = 1'b0; exp_rdk[i] = 0; exp_vin[i] = '0;
                exp_dv[i] = 1'b0; exp_row[i] = 0;
            end
            t_next = rc + 1;
        end
    endtask

    task automatic apply(input int c);
        rst_n              = in_rst_n[c];
        bus.start          = in_start[c];
        bus.k_len          = in_k[c];
        bus.mode_fp8_in    = in_mode[c];
        bus.out_bf16_en_in = in_bf16[c];
        bus.mac_valid_all  = in_mac[c];
        bus.drain_ready    = in_ready[c];
    endtask

    task automatic chk(input string nm, input int got, input int exp_v);
        total++;
        if (got != exp_v) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp_v);
        end
    endtask

    initial begin
        int t, tn, k, d, ra;
        for (int i = 0; i < N; i++) begin
            in_rst_n[i] = 1'b1;
            in_k[i]     = '0;
            in_mac[i]   = 1'($urandom_range(0, 1));
            in_ready[i] = 1'($urandom_range(0, 1));
            exp_vin[i]  = '0;
        end
        // reset held for two cycles with a start request that must be ignored
        for (int i = 0; i < 2; i++) begin
            in_rst_n[i] = 1'b0;
            in_start[i] = 1'b1;
            in_k[i]     = K_W'(5);
            in_mode[i]  = 1'b1;
        end

        plan_tile(4, 3, 1'b1, 1'b0, 6, 0, 1, 1'b0, tn);
        in_start[7] = 1'b1; in_k[7] = K_W'(9); in_mode[7] = 1'b0;
        t = tn + 2;
        plan_tile(t, 5, 1'b0, 1'b1, 3, 4, 0, 1'b0, tn);
        t = tn + 2;
        plan_tile(t, 3, 1'b1, 1'b1, 6, 0, 2, 1'b0, tn);
        t4 = tn + 2;
        plan_tile(t4, 3, 1'b0, 1'b0, TIMEOUT + 5, 0, 0, 1'b1, tn);
        t = tn + 1;
        plan_tile(t, 1, 1'b1, 1'b0, 0, 0, 1, 1'b0, tn);
        t = tn + 1;
        plan_tile(t, 0, 1'b0, 1'b1, 0, 0, 0, 1'b0, tn);
        t = tn;
        plan_tile(t, 2, 1'b1, 1'b1, TIMEOUT - 1, 0, 0, 1'b1, tn);
        t = tn + 1;
        plan_tile(t, 255, 1'b0, 1'b1, 2, 0, 1, 1'b0, tn);
        t = tn + 1;
        while (t < N - 450) begin
            k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            d  = int'($urandom_range(0, TIMEOUT + 4));
            ra = (k > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, k + 1)) : 0;
            plan_tile(t, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, ra, 0, 1'b1, tn);
            t = tn + int'($urandom_range(0, 2));
        end
        last_cyc = t + 10;

        apply(0);
        for (int c = 1; c <= last_cyc; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            apply(c);
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("busy",        int'(bus.busy),        int'(exp_busy[cyc]));
                chk("done",        int'(bus.done),        int'(exp_done[cyc]));
                chk("err_timeout", int'(bus.err_timeout), int'(exp_err[cyc]));
                chk("mode_fp8",    int'(bus.mode_fp8),    int'(exp_mode[cyc]));
                chk("out_bf16_en", int'(bus.out_bf16_en), int'(exp_bf16[cyc]));
                chk("clear_accum", int'(bus.clear_accum), int'(exp_clear[cyc]));
                chk("op_rd_en",    int'(bus.op_rd_en),    int'(exp_rd[cyc]));
                chk("op_rd_k",     int'(bus.op_rd_k),     exp_rdk[cyc]);
                chk("valid_in",    int'(bus.valid_in),    int'(exp_vin[cyc]));
                chk("drain_valid", int'(bus.drain_valid), int'(exp_dv[cyc]));
                chk("drain_row",   int'(bus.drain_row),   exp_row[cyc]);
                // hand-derived points of the first tile (start at 4, k=3) and the timeout tile
                if (cyc == 2)  chk("pin_reset_idle", int'({bus.busy, bus.mode_fp8, bus.clear_accum}), 0);
                if (cyc == 5)  chk("pin_clear", int'(bus.clear_accum), 1);
                if (cyc == 8)  chk("pin_rdk2", int'({bus.op_rd_en, bus.op_rd_k}), 9'h102);
                if (cyc == 12) chk("pin_vin3", int'(bus.valid_in), 8);
                if (cyc == 19) chk("pin_row3", int'({bus.drain_valid, bus.drain_row}), 7);
                if (cyc == 20) chk("pin_done", int'({bus.done, bus.mode_fp8, bus.err_timeout}), 6);
                if (cyc == 21) chk("pin_idle", int'({bus.busy, bus.done}), 0);
                if (cyc == t4 + 36) chk("pin_wait_last", int'({bus.busy, bus.done, bus.err_timeout}), 4);
                if (cyc == t4 + 37) chk("pin_timeout", int'({bus.done, bus.err_timeout, bus.drain_valid}), 6);
            end
        end
    end
endmodule
